// File: rtl/seg7_count_display.sv
// Four-digit multiplexed seven-segment driver for the 4-bit up/down counter: count, wrap tally, direction glyph.
// Optional full-display flash on each wrap event, compiled in when SEG7_FLASH_EN is defined.
module seg7_count_display #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned FLASH_HALF   = 2500000,
    parameter int unsigned FLASH_BLINKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] value,
    input  logic       forward,
    input  logic       enable,
    input  logic       finish,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

    localparam logic [6:0] GLYPH_UP   = 7'b1000001;
    localparam logic [6:0] GLYPH_DOWN = 7'b0100001;

    if (REFRESH_DIV < 2 || FLASH_HALF < 1 || FLASH_BLINKS < 1) begin : g_bad_cfg
        $error("seg7_count_display: invalid timing parameters");
    end

    logic [3:0] value_q;
    logic       forward_q;
    logic       enable_q;
    logic       finish_q;
    logic       finish_q2;
    logic       wrap_evt;

    logic [7:0]    wraps;
    logic [RW-1:0] refresh;
    logic [1:0]    idx;
    logic          blank;

    logic [6:0] seg_d;
    logic       dp_d;
    logic [3:0] an_d;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q   <= '0;
            forward_q <= 1'b0;
            enable_q  <= 1'b0;
            finish_q  <= 1'b0;
            finish_q2 <= 1'b0;
        end else begin
            value_q   <= value;
            forward_q <= forward;
            enable_q  <= enable;
            finish_q  <= finish;
            finish_q2 <= finish_q;
        end
    end

    // A held-high finish level produces exactly one event on its rising edge.
    assign wrap_evt = finish_q & ~finish_q2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wraps <= '0;
        end else if (wrap_evt) begin
            wraps <= wraps + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh <= '0;
            idx     <= '0;
        end else if (refresh == REF_LAST) begin
            refresh <= '0;
            idx     <= idx + 2'd1;
        end else begin
            refresh <= refresh + RW'(1);
        end
    end

`ifdef SEG7_FLASH_EN
    localparam int unsigned TW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int unsigned BW = $clog2(FLASH_BLINKS + 1);
    localparam logic [TW-1:0] HALF_LAST   = TW'(FLASH_HALF - 1);
    localparam logic [BW-1:0] BLINKS_INIT = BW'(FLASH_BLINKS);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        LIT
    } flash_state_t;

    flash_state_t  state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [BW-1:0] blinks, blinks_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            timer  <= '0;
            blinks <= '0;
        end else begin
            state  <= state_d;
            timer  <= timer_d;
            blinks <= blinks_d;
        end
    end

    always_comb begin
        state_d  = state;
        timer_d  = timer;
        blinks_d = blinks;
        if (wrap_evt) begin
            // Any wrap event, in any state, restarts the whole sequence.
            state_d  = BLANK;
            timer_d  = '0;
            blinks_d = BLINKS_INIT;
        end else begin
            case (state)
                BLANK: begin
                    if (timer == HALF_LAST) begin
                        state_d = LIT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer + TW'(1);
                    end
                end
                LIT: begin
                    if (timer == HALF_LAST) begin
                        timer_d = '0;
                        if (blinks > BW'(1)) begin
                            state_d  = BLANK;
                            blinks_d = blinks - BW'(1);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        timer_d = timer + TW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign blank = (state == BLANK);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_d = '1;
        dp_d  = 1'b1;
        an_d  = ~(4'b0001 << idx);
        case (idx)
            2'd0: begin
                seg_d = hex7(value_q);
                dp_d  = ~enable_q;
            end
            2'd1:    seg_d = hex7(wraps[3:0]);
            2'd2:    seg_d = hex7(wraps[7:4]);
            default: seg_d = forward_q ? GLYPH_UP : GLYPH_DOWN;
        endcase
        if (blank) begin
            an_d  = '1;
            seg_d = '1;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= '1;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= seg_d;
            dp  <= dp_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_seg7_count_display.sv
// Scoreboard bench for seg7_count_display: stimulus queues expected display per cycle, a negedge monitor checks.
// Flash expectations follow SEG7_FLASH_EN so the same bench serves both builds.
module tb_seg7_count_display;

`ifdef SEG7_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] GU = 7'b1000001;
    localparam logic [6:0] GD = 7'b0100001;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] value;
    logic       forward;
    logic       enable;
    logic       finish;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    seg7_count_display #(
        .REFRESH_DIV (4),
        .FLASH_HALF  (8),
        .FLASH_BLINKS(2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .value  (value),
        .forward(forward),
        .enable (enable),
        .finish (finish),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        bit          chk;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned rel0 = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.cyc != cyc) begin
                $display("FAIL %s stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else if (an !== e.an || (e.chk && (seg !== e.seg || dp !== e.dp))) begin
                $display("FAIL %s cyc=%0d an=%b seg=%b dp=%b required an=%b seg=%b dp=%b (seg/dp checked=%0d)",
                         e.name, cyc, an, seg, dp, e.an, e.seg, e.dp, e.chk);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int unsigned rel();
        return cyc - rel0;
    endfunction

    task automatic wait_rel(input int unsigned k);
        while (rel() < k) step(1);
    endtask

    // Digit d is selected on edges k where ((k-1)/4) mod 4 == d, counting edges since reset release.
    function automatic logic [3:0] exp_an(input int unsigned k);
        logic [1:0] d;
        d = 2'(((k - 1) / 4) % 4);
        return ~(4'b0001 << d);
    endfunction

    function automatic int unsigned next_start(input int unsigned d, input int unsigned from);
        int unsigned k;
        k = from;
        while (((k - 1) % 4) != 0 || (((k - 1) / 4) % 4) != d) k++;
        return k;
    endfunction

    task automatic push_abs(input int unsigned c, input logic [3:0] a, input logic [6:0] s,
                            input logic d, input bit chk, input string nm);
        exp_t e;
        e = '{c, a, s, d, chk, nm};
        sb.push_back(e);
    endtask

    task automatic push_blank(input int unsigned k, input string nm);
        push_abs(rel0 + k, 4'b1111, 7'b1111111, 1'b1, 1'b1, nm);
    endtask

    task automatic push_scan(input int unsigned k, input string nm);
        push_abs(rel0 + k, exp_an(k), 7'b0, 1'b0, 1'b0, nm);
    endtask

    task automatic push_full(input int unsigned k, input logic [6:0] s, input logic d, input string nm);
        push_abs(rel0 + k, exp_an(k), s, d, 1'b1, nm);
    endtask

    task automatic check_digit(input int unsigned d, input logic [6:0] s, input logic dpx, input string nm);
        int unsigned k;
        k = next_start(d, rel() + 1);
        for (int unsigned i = 0; i < 4; i++) push_full(k + i, s, dpx, nm);
        wait_rel(k + 3);
    endtask

    task automatic push_flash(input int unsigned e, input int unsigned b0, input int unsigned b1,
                              input int unsigned b2, input int unsigned b3, input string nm);
        for (int unsigned k = e + 2; k <= e + 34; k++) begin
            if (FLASH && ((k >= e + b0 && k <= e + b1) || (k >= e + b2 && k <= e + b3)))
                push_blank(k, nm);
            else
                push_scan(k, nm);
        end
    endtask

    task automatic pulse(input int unsigned hi, input int unsigned lo);
        finish = 1'b1;
        step(hi);
        finish = 1'b0;
        step(lo);
    endtask

    task automatic scan_table(input int unsigned first, input int unsigned last,
                              input logic [6:0] s0, input logic p0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input string nm);
        for (int unsigned k = first; k <= last; k++) begin
            case (((k - 1) / 4) % 4)
                0:       push_full(k, s0, p0, nm);
                1:       push_full(k, s1, 1'b1, nm);
                2:       push_full(k, s2, 1'b1, nm);
                default: push_full(k, s3, 1'b1, nm);
            endcase
        end
    endtask

    initial begin
        int unsigned e;
        reset   = 1'b1;
        value   = 4'h0;
        forward = 1'b0;
        enable  = 1'b0;
        finish  = 1'b0;
        step(2);

        // Reset and scan order
        value   = 4'hA;
        forward = 1'b1;
        enable  = 1'b1;
        push_abs(cyc + 1, 4'b1111, 7'b1111111, 1'b1, 1'b1, "in_reset");
        push_abs(cyc + 2, 4'b1111, 7'b1111111, 1'b1, 1'b1, "in_reset");
        step(2);
        reset = 1'b0;
        rel0  = cyc;
        push_abs(rel0 + 1, 4'b1110, 7'b0, 1'b0, 1'b0, "first_edge");
        scan_table(2, 17, GA, 1'b0, G0, G0, GU, "scan");
        wait_rel(18);

        // Asynchronous reset mid-scan
        push_abs(cyc, 4'b1111, 7'b1111111, 1'b1, 1'b1, "async_reset");
        push_abs(cyc + 1, 4'b1111, 7'b1111111, 1'b1, 1'b1, "async_reset");
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        rel0  = cyc;
        push_abs(rel0 + 1, 4'b1110, 7'b0, 1'b0, 1'b0, "rerelease");
        scan_table(2, 4, GA, 1'b0, G0, G0, GU, "rerelease");
        wait_rel(4);

        // Direction, value latency, decimal point
        forward = 1'b0;
        value   = 4'h1;
        check_digit(3, GD, 1'b1, "dir_down");
        check_digit(0, G1, 1'b0, "value_1");
        wait_rel(next_start(0, rel() + 1));
        value = 4'h8;
        push_full(rel() + 1, G1, 1'b0, "val_old");
        push_full(rel() + 2, G8, 1'b0, "val_new");
        push_full(rel() + 3, G8, 1'b0, "val_new");
        wait_rel(rel() + 3);
        enable = 1'b0;
        check_digit(0, G8, 1'b1, "dp_off");

        // Wrap counting: 17 long pulses count once each
        for (int i = 0; i < 17; i++) pulse(5, 3);
        step(45);
        check_digit(1, G1, 1'b1, "wraps_lo_11");
        check_digit(2, G1, 1'b1, "wraps_hi_11");

        // Single flash
        e = rel();
        push_flash(e, 3, 10, 19, 26, "flash");
        pulse(2, 0);
        wait_rel(e + 34);
        check_digit(1, G2, 1'b1, "wraps_12");

        // Retrigger at the fifth blank cycle
        e = rel();
        push_flash(e, 3, 16, 25, 32, "retrigger");
        pulse(2, 4);
        pulse(2, 0);
        wait_rel(e + 34);
        check_digit(1, G4, 1'b1, "wraps_14");

        // Reset during blank phase
        e = rel();
        pulse(2, 0);
        wait_rel(e + 5);
        push_abs(cyc, 4'b1111, 7'b1111111, 1'b1, 1'b1, "rst_midflash");
        push_abs(cyc + 1, 4'b1111, 7'b1111111, 1'b1, 1'b1, "rst_midflash");
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        rel0  = cyc;
        push_abs(rel0 + 1, 4'b1110, 7'b0, 1'b0, 1'b0, "post_rst");
        scan_table(2, 16, G8, 1'b1, G0, G0, GD, "post_rst");
        wait_rel(16);

        // Overflow 0xFF -> 0x00 with flash
        for (int i = 0; i < 255; i++) pulse(2, 2);
        step(40);
        check_digit(1, GF, 1'b1, "wraps_ff_lo");
        check_digit(2, GF, 1'b1, "wraps_ff_hi");
        e = rel();
        push_flash(e, 3, 10, 19, 26, "ovf_flash");
        pulse(2, 0);
        wait_rel(e + 34);
        check_digit(1, G0, 1'b1, "ovf_lo");
        check_digit(2, G0, 1'b1, "ovf_hi");

        step(5);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL leftover %0d expectations never reached, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
